// File: rtl/dmem_io_if.sv
// Core-to-data-memory bus: store strobe, byte address, store data and load data.
// wemem qualifies a store at the rising edge; rdata is always valid combinationally for addr (no handshake stalls).
interface dmem_io_if;
  logic        wemem;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output wemem, addr, wdata, input rdata);
  modport slave  (input wemem, addr, wdata, output rdata);
endinterface

// File: rtl/dmem_io.sv
// Data-side memory for the single-cycle core: word RAM, LED register, timer with
// compare interrupt, and an 8N1 UART transmitter fed from a small TX FIFO.
module dmem_io #(
  parameter int RAM_WORDS    = 1024,
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  dmem_io_if.slave   bus,
  output logic [7:0] leds,
  output logic       uart_tx,
  output logic       irq,
  output logic [1:0] uart_state
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE = CW'(1);
  localparam logic [FW:0]   CNT_FULL = (FW+1)'(FIFO_DEPTH);
  localparam logic [FW:0]   CNT_ONE  = (FW+1)'(1);
  localparam logic [FW-1:0] PTR_ONE  = FW'(1);

  localparam logic [29:0] W_LED   = 30'h3FFF_FFC0;
  localparam logic [29:0] W_TIMER = 30'h3FFF_FFC1;
  localparam logic [29:0] W_CMP   = 30'h3FFF_FFC2;
  localparam logic [29:0] W_TSTAT = 30'h3FFF_FFC3;
  localparam logic [29:0] W_TXD   = 30'h3FFF_FFC4;
  localparam logic [29:0] W_USTAT = 30'h3FFF_FFC5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  logic [29:0] word;
  logic        is_ram;
  logic        wr_led, wr_timer, wr_cmp, wr_tstat, wr_txd, wr_ustat;
  logic        unused_addr_bits;

  assign word             = bus.addr[31:2];
  assign is_ram           = (bus.addr[31:AW+2] == '0);
  assign wr_led           = bus.wemem && (word == W_LED);
  assign wr_timer         = bus.wemem && (word == W_TIMER);
  assign wr_cmp           = bus.wemem && (word == W_CMP);
  assign wr_tstat         = bus.wemem && (word == W_TSTAT);
  assign wr_txd           = bus.wemem && (word == W_TXD);
  assign wr_ustat         = bus.wemem && (word == W_USTAT);
  assign unused_addr_bits = ^bus.addr[1:0];

  // RAM has no reset: contents are undefined until software writes them.
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (bus.wemem && is_ram) ram[bus.addr[AW+1:2]] <= bus.wdata;
  end

  logic [31:0] timer, cmp;
  logic        match, ie;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds  <= 8'h00;
      timer <= 32'h0;
      cmp   <= 32'hFFFF_FFFF;
      match <= 1'b0;
      ie    <= 1'b0;
    end else begin
      if (wr_led) leds <= bus.wdata[7:0];
      timer <= wr_timer ? bus.wdata : timer + 32'd1;
      if (wr_cmp) cmp <= bus.wdata;
      // A compare hit in the same cycle as a W1C keeps match set.
      match <= (timer == cmp) || (match && !(wr_tstat && bus.wdata[0]));
      if (wr_tstat) ie <= bus.wdata[1];
    end
  end

  assign irq = match & ie;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr, rd_ptr;
  logic [FW:0]   count;
  logic          fifo_full, fifo_empty, overflow, pop, push_ok;

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);
  // A push into a full FIFO still lands if the UART drains an entry that same edge.
  assign push_ok    = wr_txd && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (wr_txd && fifo_full && !pop) overflow <= 1'b1;
      else if (wr_ustat)               overflow <= 1'b0;
    end
  end

  uart_state_t   state, state_n;
  logic [CW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, sh_n;
  logic          tx_n, tx_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shreg   <= sh_n;
      uart_tx <= tx_n;
    end
  end

  // Next line level is computed here so uart_tx comes straight from a flop.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    sh_n    = shreg;
    tx_n    = uart_tx;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_n    = fifo_mem[rd_ptr];
          baud_n  = '0;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (baud == BAUD_MAX) begin
          baud_n  = '0;
          bit_n   = 3'd0;
          state_n = DATA;
          tx_n    = shreg[0];
        end else begin
          baud_n = baud + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud == BAUD_MAX) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_idx + 3'd1;
            sh_n  = {1'b0, shreg[7:1]};
            tx_n  = shreg[1];
          end
        end else begin
          baud_n = baud + BAUD_ONE;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (baud == BAUD_MAX) begin
          baud_n  = '0;
          state_n = IDLE;
        end else begin
          baud_n = baud + BAUD_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign tx_busy    = (state != IDLE);
  assign uart_state = state;

  always_comb begin
    bus.rdata = 32'h0;
    if (is_ram)                bus.rdata = ram[bus.addr[AW+1:2]];
    else if (word == W_LED)    bus.rdata = {24'h0, leds};
    else if (word == W_TIMER)  bus.rdata = timer;
    else if (word == W_CMP)    bus.rdata = cmp;
    else if (word == W_TSTAT)  bus.rdata = {30'h0, ie, match};
    else if (word == W_USTAT)  bus.rdata = {16'h0, 8'(count), 4'h0, overflow, tx_busy,
                                            fifo_empty, fifo_full};
  end

endmodule
